hilo_reg_unit: RTL and testbench

- Downstream stage of the 32x32 combinational multiplier.
- Captures the 64-bit product {Y_hi,Y_lo} into architectural HI/LO registers after a modelled multi-cycle multiply latency.
- Serves MFHI/MFLO reads and MTHI/MTLO writes.
- Drives a stall interlock back to the pipeline control while a product is pending.

---
 rtl/hilo_pkg.sv | 18 +
 rtl/hilo_latency_ctr.sv | 29 ++
 rtl/hilo_reg_unit.sv | 99 +++++++++
 tb/tb_hilo_reg_unit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// Shared constants and types for the HI/LO register unit and its latency counter.
package hilo_pkg;

  localparam int DW          = 32;
  localparam int LATENCY_MAX = 15;
  localparam int CNT_W       = 4;
  localparam logic [4:0] FS_MULT = 5'h1E;

  typedef struct packed {
    logic n;
    logic z;
  } flags_t;

  function automatic logic [CNT_W-1:0] lat_load(input int lat);
    return CNT_W'(lat);
  endfunction

endpackage

// File: rtl/hilo_latency_ctr.sv
// Loadable down-counter modelling multiply latency; commit marks the final busy cycle.
// Latency: busy rises the edge after load; no backpressure (load only while idle).
module hilo_latency_ctr
  import hilo_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             busy,
  output logic             commit
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign busy   = (cnt != '0);
  assign commit = (cnt == CNT_W'(1));

endmodule

// File: rtl/hilo_reg_unit.sv
// HI/LO architectural registers fed by the multiplier; HILO_FWD_EN enables read bypass in the commit cycle.
// Latency: product lands LATENCY edges after accept; reads return on the next edge.
// Backpressure: stall is combinational, requester holds any request not accepted.
module hilo_reg_unit
  import hilo_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mpy_start,
  input  logic [DW-1:0] Y_hi,
  input  logic [DW-1:0] Y_lo,
  input  logic          mthi,
  input  logic          mtlo,
  input  logic [DW-1:0] wr_data,
  input  logic          mfhi,
  input  logic          mflo,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          stall,
  output logic          busy,
  output logic [DW-1:0] HI,
  output logic [DW-1:0] LO,
  output logic          N,
  output logic          Z
);

  logic [2*DW-1:0] pending;
  logic [DW-1:0]   rd_src;
  flags_t          flags;
  logic            commit;
  logic            mt_req, mf_req;
  logic            accept_mpy, accept_mt, accept_mf, fwd_rd;

  hilo_latency_ctr u_ctr (
    .clk      (clk),
    .reset    (reset),
    .load     (accept_mpy),
    .load_val (lat_load(LATENCY)),
    .busy     (busy),
    .commit   (commit)
  );

  assign mt_req     = mthi | mtlo;
  assign mf_req     = mfhi | mflo;
  assign accept_mpy = mpy_start & ~busy;
  assign accept_mt  = mt_req & ~busy & ~mpy_start;

`ifdef HILO_FWD_EN
  // Pending is stable in the commit cycle, so a read can take it directly.
  assign fwd_rd = commit & mf_req;
`else
  assign fwd_rd = 1'b0;
`endif

  assign accept_mf = (mf_req & ~busy & ~mpy_start) | fwd_rd;
  assign stall     = (mpy_start & ~accept_mpy) | (mt_req & ~accept_mt) | (mf_req & ~accept_mf);

  always_comb begin
    rd_src = mfhi ? HI : LO;
    if (fwd_rd) begin
      rd_src = mfhi ? pending[2*DW-1:DW] : pending[DW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pending  <= '0;
      HI       <= '0;
      LO       <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      flags    <= '0;
    end else begin
      rd_valid <= accept_mf;
      if (accept_mpy) begin
        pending <= {Y_hi, Y_lo};
      end
      // Commit and MT writes are mutually exclusive: MT is only accepted while idle.
      if (commit) begin
        {HI, LO} <= pending;
        flags.n  <= pending[2*DW-1];
        flags.z  <= (pending == '0);
      end else begin
        if (accept_mt & mthi) HI <= wr_data;
        if (accept_mt & mtlo) LO <= wr_data;
      end
      if (accept_mf) begin
        rd_data <= rd_src;
      end
    end
  end

  assign N = flags.n;
  assign Z = flags.z;

endmodule

// File: tb/tb_hilo_reg_unit.sv
// Directed table-driven bench for hilo_reg_unit plus hand sequences for back-to-back and mid-op reset.
module tb_hilo_reg_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mpy_start;
  logic [31:0] Y_hi, Y_lo;
  logic        mthi, mtlo;
  logic [31:0] wr_data;
  logic        mfhi, mflo;
  logic [31:0] rd_data;
  logic        rd_valid, stall, busy;
  logic [31:0] HI, LO;
  logic        N, Z;

`ifdef HILO_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  always #5 clk = ~clk;

  hilo_reg_unit #(.LATENCY(4), .DW(32)) dut (
    .clk(clk), .reset(reset), .mpy_start(mpy_start), .Y_hi(Y_hi), .Y_lo(Y_lo),
    .mthi(mthi), .mtlo(mtlo), .wr_data(wr_data), .mfhi(mfhi), .mflo(mflo),
    .rd_data(rd_data), .rd_valid(rd_valid), .stall(stall), .busy(busy),
    .HI(HI), .LO(LO), .N(N), .Z(Z)
  );

  typedef struct {
    logic        mpy;
    logic [31:0] yhi;
    logic [31:0] ylo;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wd;
    logic        mfhi;
    logic        mflo;
    logic        e_stall;
    logic        e_busy;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
    logic        e_rv;
    logic [31:0] e_rd;
    logic        e_n;
    logic        e_z;
  } vec_t;

  localparam int NV = 23;
  vec_t tv [NV];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    mpy_start = v.mpy;
    Y_hi      = v.yhi;
    Y_lo      = v.ylo;
    mthi      = v.mthi;
    mtlo      = v.mtlo;
    wr_data   = v.wd;
    mfhi      = v.mfhi;
    mflo      = v.mflo;
  endtask

  task automatic idle_in();
    mpy_start = 1'b0; Y_hi = '0; Y_lo = '0;
    mthi = 1'b0; mtlo = 1'b0; wr_data = '0;
    mfhi = 1'b0; mflo = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // mpy  yhi           ylo           mthi mtlo wd            mfhi mflo | stall busy hi            lo            rv   rd                          n    z
    tv[0]  = '{1'b1, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         32'h0,         1'b0, 32'h0,                      1'b0, 1'b0};
    tv[1]  = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b1, 32'h0,         32'h0,         1'b0, 32'h0,                      1'b0, 1'b0};
    tv[2]  = tv[1];
    tv[3]  = tv[1];
    // commit cycle: read stalls unless bypass is built in
    tv[4]  = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 1'b1, !FWD, 1'b0, 32'h1,         32'hFFFF_FFFE, FWD,  FWD ? 32'hFFFF_FFFE : 32'h0, 1'b0, 1'b0};
    tv[5]  = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'h1,         32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFE,              1'b0, 1'b0};
    tv[6]  = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h1,         32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFE,              1'b0, 1'b0};
    tv[7]  = '{1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'hFFFF_FFFE, 1'b1, 32'h1,                      1'b0, 1'b0};
    tv[8]  = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'hFFFF_FFFE, 1'b1, 32'hDEAD_BEEF,              1'b0, 1'b0};
    tv[9]  = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 32'hDEAD_BEEF,              1'b0, 1'b0};
    tv[10] = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 32'hDEAD_BEEF,              1'b0, 1'b0};
    tv[11] = '{1'b0, 32'h0,         32'h0,         1'b1, 1'b1, 32'hA5A5_5A5A, 1'b0, 1'b0, 1'b0, 1'b0, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 1'b0, 32'hDEAD_BEEF,              1'b0, 1'b0};
    // multiply wins over a same-cycle mtlo
    tv[12] = '{1'b1, 32'h8000_0000, 32'h0,         1'b0, 1'b1, 32'h1111_1111, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 1'b0, 32'hDEAD_BEEF,              1'b0, 1'b0};
    tv[13] = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b1, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 1'b0, 32'hDEAD_BEEF,              1'b0, 1'b0};
    tv[14] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 1'b0, 32'hDEAD_BEEF,              1'b0, 1'b0};
    tv[15] = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 1'b0, 32'hDEAD_BEEF,              1'b0, 1'b0};
    tv[16] = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'h0,         1'b0, 32'hDEAD_BEEF,              1'b1, 1'b0};
    tv[17] = '{1'b1, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'h0,         1'b0, 32'hDEAD_BEEF,              1'b1, 1'b0};
    tv[18] = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'h0,         1'b0, 32'hDEAD_BEEF,              1'b1, 1'b0};
    tv[19] = tv[18];
    tv[20] = tv[18];
    tv[21] = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 32'hDEAD_BEEF,              1'b0, 1'b1};
    // MT leaves flags alone
    tv[22] = '{1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 32'h0000_0077, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0077, 32'h0,         1'b0, 32'hDEAD_BEEF,              1'b0, 1'b1};

    reset = 1'b0;
    idle_in();
    tick();
    tick();
    chk("rst busy", busy, 0);
    chk("rst HI", HI, 0);
    chk("rst LO", LO, 0);
    chk("rst rd_valid", rd_valid, 0);
    chk("rst rd_data", rd_data, 0);
    chk("rst N", N, 0);
    chk("rst Z", Z, 0);
    chk("rst stall", stall, 0);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(tv[i]);
      #1;
      chk($sformatf("r%0d stall", i), stall, tv[i].e_stall);
      tick();
      chk($sformatf("r%0d busy", i), busy, tv[i].e_busy);
      chk($sformatf("r%0d HI", i), HI, tv[i].e_hi);
      chk($sformatf("r%0d LO", i), LO, tv[i].e_lo);
      chk($sformatf("r%0d rd_valid", i), rd_valid, tv[i].e_rv);
      chk($sformatf("r%0d rd_data", i), rd_data, tv[i].e_rd);
      chk($sformatf("r%0d N", i), N, tv[i].e_n);
      chk($sformatf("r%0d Z", i), Z, tv[i].e_z);
    end

    // Back-to-back: requester holds mpy_start through the stall window.
    idle_in();
    mpy_start = 1'b1; Y_hi = 32'h5; Y_lo = 32'h6;
    #1;
    chk("b2b first stall", stall, 0);
    tick();
    Y_hi = 32'h7; Y_lo = 32'h8;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("b2b hold stall %0d", k), stall, 1);
      tick();
    end
    chk("b2b first HI", HI, 32'h5);
    chk("b2b first LO", LO, 32'h6);
    chk("b2b idle gap busy", busy, 0);
    chk("b2b second stall", stall, 0);
    tick();
    mpy_start = 1'b0;
    chk("b2b second busy", busy, 1);
    tick();
    tick();
    tick();
    chk("b2b HI before commit", HI, 32'h5);
    tick();
    chk("b2b second HI", HI, 32'h7);
    chk("b2b second LO", LO, 32'h8);
    chk("b2b second busy done", busy, 0);

    // Reset while cnt==2 discards the pending product.
    mpy_start = 1'b1; Y_hi = 32'h9; Y_lo = 32'h9;
    tick();
    idle_in();
    tick();
    tick();
    chk("midrst busy before", busy, 1);
    reset = 1'b0;
    tick();
    chk("midrst busy", busy, 0);
    chk("midrst HI", HI, 0);
    chk("midrst LO", LO, 0);
    reset = 1'b1;
    repeat (6) tick();
    chk("midrst no commit HI", HI, 0);
    chk("midrst no commit LO", LO, 0);
    chk("midrst busy later", busy, 0);
    chk("midrst Z", Z, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
